pipeline_hazard_ctrl: RTL and testbench

//  Central stall/flush sequencer for the 5-stage RV32I pipeline.

---
 rtl/pipeline_hazard_ctrl_pkg.sv | 33 +++
 rtl/pipeline_hazard_ctrl_load_use.sv | 24 ++
 rtl/pipeline_hazard_ctrl.sv | 219 +++++++++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types and constants for the RV32I pipeline hazard controller.
// The top module pipeline_hazard_ctrl has an optional build macro,
// HAZARD_PERF_CNT_EN, which adds performance counters.
package riscv_pipe_pkg;

  // Controller states; MEM_WAIT remembers which of the others it froze.
  typedef enum logic [1:0] {
    HZ_RUN        = 2'd0,
    HZ_LOAD_STALL = 2'd1,
    HZ_FLUSH      = 2'd2,
    HZ_MEM_WAIT   = 2'd3
  } hz_state_t;

  // x0 is hardwired to zero, so a load targeting it never creates a hazard.
  localparam logic [4:0] REG_X0 = 5'd0;

  // Hazard priority codes: the larger value wins when sources coincide.
  localparam logic [1:0] HZ_PRIO_NONE     = 2'd0;
  localparam logic [1:0] HZ_PRIO_LOAD_USE = 2'd1;
  localparam logic [1:0] HZ_PRIO_MISPRED  = 2'd2;
  localparam logic [1:0] HZ_PRIO_MEM      = 2'd3;

  // Picks the hazard source that owns this cycle.
  function automatic logic [1:0] hz_select(input logic mem_busy,
                                           input logic mispredict,
                                           input logic load_use);
    if (mem_busy)        return HZ_PRIO_MEM;
    else if (mispredict) return HZ_PRIO_MISPRED;
    else if (load_use)   return HZ_PRIO_LOAD_USE;
    else                 return HZ_PRIO_NONE;
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_load_use.sv
// Load-use hazard compare: the load in EX writes a register that the
// instruction in ID actually reads.
module hz_load_use_detect
  import riscv_pipe_pkg::*;
(
  input  logic       i_id_valid,
  input  logic [4:0] i_id_rs1,
  input  logic [4:0] i_id_rs2,
  input  logic       i_id_uses_rs2,
  input  logic       i_ex_valid,
  input  logic [4:0] i_ex_rd,
  input  logic       i_ex_memread,
  output logic       o_load_use
);

  logic w_rs1_hit;
  logic w_rs2_hit;

  assign w_rs1_hit  = (i_ex_rd == i_id_rs1);
  assign w_rs2_hit  = i_id_uses_rs2 & (i_ex_rd == i_id_rs2);
  assign o_load_use = i_ex_valid & i_ex_memread & (i_ex_rd != REG_X0) &
                      i_id_valid & (w_rs1_hit | w_rs2_hit);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage RV32I pipeline.
// Drives PC, IF/ID and ID/EX write enables plus flush/redirect controls.
// Priority: mem_busy > ex_mispredict > load-use.
// Optional macro HAZARD_PERF_CNT_EN adds perf_stall_cycles/perf_flush_count.
// Outputs are combinational from the registered state and current inputs.
// dbg_state exposes the registered FSM state.
module pipeline_hazard_ctrl
  import riscv_pipe_pkg::*;
#(
  parameter int unsigned LOAD_USE_STALL = 1,
  parameter int unsigned FLUSH_CYCLES   = 1,
  parameter int unsigned MEM_TIMEOUT    = 256
)
(
  input  logic        clk,
  input  logic        rst,
  input  logic        id_valid,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_uses_rs2,
  input  logic        ex_valid,
  input  logic [4:0]  ex_rd,
  input  logic        ex_memread,
  input  logic        ex_mispredict,
  input  logic [31:0] ex_redirect_pc,
  input  logic        mem_busy,
  output logic        pc_write_en,
  output logic        if_id_write_en,
  output logic        id_ex_write_en,
  output logic        if_id_flush,
  output logic        id_ex_flush,
  output logic        pc_redirect_valid,
  output logic [31:0] pc_redirect,
  output logic        stall,
  output logic        mem_timeout_err,
  output logic [1:0]  dbg_state
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0] perf_stall_cycles,
  output logic [31:0] perf_flush_count
`endif
);

  localparam bit          LU_MULTI  = (LOAD_USE_STALL > 1);
  localparam bit          FL_MULTI  = (FLUSH_CYCLES > 1);
  localparam logic [2:0]  LU_RELOAD = 3'(LOAD_USE_STALL - 1);
  localparam logic [2:0]  FL_RELOAD = 3'(FLUSH_CYCLES - 1);
  localparam logic [15:0] MEM_LIMIT = 16'(MEM_TIMEOUT - 1);

  hz_state_t   r_state;
  hz_state_t   r_saved_state;
  hz_state_t   w_state_nxt;
  hz_state_t   w_eff_state;
  logic [2:0]  r_cnt;
  logic [2:0]  r_saved_cnt;
  logic [2:0]  w_cnt_nxt;
  logic [2:0]  w_eff_cnt;
  logic [15:0] r_mem_cnt;
  logic [15:0] w_mem_cnt_nxt;
  logic        r_timeout_err;
  logic        w_load_use;
  logic        w_release;
  logic        w_waiting;
  logic        w_serviced;
  logic [1:0]  w_prio;

  hz_load_use_detect u_load_use (
    .i_id_valid    (id_valid),
    .i_id_rs1      (id_rs1),
    .i_id_rs2      (id_rs2),
    .i_id_uses_rs2 (id_uses_rs2),
    .i_ex_valid    (ex_valid),
    .i_ex_rd       (ex_rd),
    .i_ex_memread  (ex_memread),
    .o_load_use    (w_load_use)
  );

  // On the cycle memory releases, behave as the state that was frozen.
  assign w_waiting   = (r_state == HZ_MEM_WAIT);
  assign w_release   = w_waiting & ~mem_busy;
  assign w_eff_state = w_release ? r_saved_state : r_state;
  assign w_eff_cnt   = w_release ? r_saved_cnt   : r_cnt;
  assign w_prio      = hz_select(mem_busy, ex_mispredict, w_load_use);

  assign pc_redirect     = ex_redirect_pc;
  assign mem_timeout_err = r_timeout_err;
  assign dbg_state       = r_state;

  // Output decode and next-state selection by hazard priority.
  always_comb begin
    pc_write_en       = 1'b1;
    if_id_write_en    = 1'b1;
    id_ex_write_en    = 1'b1;
    if_id_flush       = 1'b0;
    id_ex_flush       = 1'b0;
    pc_redirect_valid = 1'b0;
    stall             = 1'b0;
    w_serviced        = 1'b0;
    w_state_nxt       = w_eff_state;
    w_cnt_nxt         = w_eff_cnt;
    if (rst) begin
      pc_write_en    = 1'b0;
      if_id_write_en = 1'b0;
      id_ex_write_en = 1'b0;
      if_id_flush    = 1'b1;
      id_ex_flush    = 1'b1;
    end else begin
      case (w_prio)
        HZ_PRIO_MEM: begin
          pc_write_en    = 1'b0;
          if_id_write_en = 1'b0;
          id_ex_write_en = 1'b0;
          stall          = 1'b1;
          w_state_nxt    = HZ_MEM_WAIT;
          w_cnt_nxt      = r_cnt;
        end
        HZ_PRIO_MISPRED: begin
          pc_redirect_valid = 1'b1;
          if_id_flush       = 1'b1;
          id_ex_flush       = 1'b1;
          stall             = (w_eff_state != HZ_RUN);
          w_serviced        = 1'b1;
          w_state_nxt       = FL_MULTI ? HZ_FLUSH : HZ_RUN;
          w_cnt_nxt         = FL_MULTI ? FL_RELOAD : 3'd0;
        end
        default: begin
          case (w_eff_state)
            HZ_RUN: begin
              if (w_load_use) begin
                pc_write_en    = 1'b0;
                if_id_write_en = 1'b0;
                id_ex_flush    = 1'b1;
                stall          = 1'b1;
                if (LU_MULTI) begin
                  w_state_nxt = HZ_LOAD_STALL;
                  w_cnt_nxt   = LU_RELOAD;
                end
              end
            end
            HZ_LOAD_STALL: begin
              pc_write_en    = 1'b0;
              if_id_write_en = 1'b0;
              id_ex_flush    = 1'b1;
              stall          = 1'b1;
              if (w_eff_cnt <= 3'd1) begin
                w_state_nxt = HZ_RUN;
                w_cnt_nxt   = 3'd0;
              end else begin
                w_cnt_nxt = w_eff_cnt - 3'd1;
              end
            end
            HZ_FLUSH: begin
              if_id_flush = 1'b1;
              id_ex_flush = 1'b1;
              stall       = 1'b1;
              if (w_eff_cnt <= 3'd1) begin
                w_state_nxt = HZ_RUN;
                w_cnt_nxt   = 3'd0;
              end else begin
                w_cnt_nxt = w_eff_cnt - 3'd1;
              end
            end
            default: begin
              w_state_nxt = HZ_RUN;
              w_cnt_nxt   = 3'd0;
            end
          endcase
        end
      endcase
    end
  end

  // Memory-wait cycle counter: counts frozen cycles, saturating, cleared on release.
  always_comb begin
    w_mem_cnt_nxt = r_mem_cnt;
    if (w_waiting && mem_busy) begin
      if (r_mem_cnt != 16'hFFFF) w_mem_cnt_nxt = r_mem_cnt + 16'd1;
    end else if (w_waiting) begin
      w_mem_cnt_nxt = 16'd0;
    end
  end

  // State, down-counter, saved context and sticky timeout flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= HZ_RUN;
      r_cnt         <= 3'd0;
      r_saved_state <= HZ_RUN;
      r_saved_cnt   <= 3'd0;
      r_mem_cnt     <= 16'd0;
      r_timeout_err <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_mem_cnt <= w_mem_cnt_nxt;
      if (mem_busy && !w_waiting) begin
        r_saved_state <= r_state;
        r_saved_cnt   <= r_cnt;
      end
      if (w_waiting && mem_busy && (w_mem_cnt_nxt == MEM_LIMIT)) begin
        r_timeout_err <= 1'b1;
      end
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  // Stall-cycle and serviced-mispredict counters, wrapping at 2^32.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_stall_cycles <= 32'd0;
      perf_flush_count  <= 32'd0;
    end else begin
      if (stall)      perf_stall_cycles <= perf_stall_cycles + 32'd1;
      if (w_serviced) perf_flush_count  <= perf_flush_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: a default-parameter instance (dut_d) driven
// from a vector table, and a LOAD_USE_STALL=3/FLUSH_CYCLES=3/MEM_TIMEOUT=4
// instance (dut) exercised with hand-written multi-cycle sequences.
// Output vectors are {pc_we, if_id_we, id_ex_we, if_id_flush, id_ex_flush,
// redirect_valid, stall}.
module tb_pipeline_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        id_valid, id_uses_rs2, ex_valid, ex_memread, ex_mispredict, mem_busy;
  logic [4:0]  id_rs1, id_rs2, ex_rd;
  logic [31:0] ex_redirect_pc;

  logic        a_pc_we, a_ifid_we, a_idex_we, a_ifid_fl, a_idex_fl, a_rv, a_stall, a_err;
  logic [31:0] a_pc;
  logic [1:0]  a_dbg;
  logic        d_pc_we, d_ifid_we, d_idex_we, d_ifid_fl, d_idex_fl, d_rv, d_stall, d_err;
  logic [31:0] d_pc;
  logic [1:0]  d_dbg;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] a_perf_stall, a_perf_flush, d_perf_stall, d_perf_flush;
`endif

  logic [6:0] outs_a, outs_d;
  assign outs_a = {a_pc_we, a_ifid_we, a_idex_we, a_ifid_fl, a_idex_fl, a_rv, a_stall};
  assign outs_d = {d_pc_we, d_ifid_we, d_idex_we, d_ifid_fl, d_idex_fl, d_rv, d_stall};

  int n_vec = 0;
  int n_err = 0;

  // clock and reset
  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.LOAD_USE_STALL(3), .FLUSH_CYCLES(3), .MEM_TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs2(id_uses_rs2), .ex_valid(ex_valid), .ex_rd(ex_rd),
    .ex_memread(ex_memread), .ex_mispredict(ex_mispredict),
    .ex_redirect_pc(ex_redirect_pc), .mem_busy(mem_busy),
    .pc_write_en(a_pc_we), .if_id_write_en(a_ifid_we), .id_ex_write_en(a_idex_we),
    .if_id_flush(a_ifid_fl), .id_ex_flush(a_idex_fl), .pc_redirect_valid(a_rv),
    .pc_redirect(a_pc), .stall(a_stall), .mem_timeout_err(a_err), .dbg_state(a_dbg)
`ifdef HAZARD_PERF_CNT_EN
    , .perf_stall_cycles(a_perf_stall), .perf_flush_count(a_perf_flush)
`endif
  );

  pipeline_hazard_ctrl dut_d (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs2(id_uses_rs2), .ex_valid(ex_valid), .ex_rd(ex_rd),
    .ex_memread(ex_memread), .ex_mispredict(ex_mispredict),
    .ex_redirect_pc(ex_redirect_pc), .mem_busy(mem_busy),
    .pc_write_en(d_pc_we), .if_id_write_en(d_ifid_we), .id_ex_write_en(d_idex_we),
    .if_id_flush(d_ifid_fl), .id_ex_flush(d_idex_fl), .pc_redirect_valid(d_rv),
    .pc_redirect(d_pc), .stall(d_stall), .mem_timeout_err(d_err), .dbg_state(d_dbg)
`ifdef HAZARD_PERF_CNT_EN
    , .perf_stall_cycles(d_perf_stall), .perf_flush_count(d_perf_flush)
`endif
  );

  typedef struct {
    logic        idv;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        u2;
    logic        exv;
    logic [4:0]  rd;
    logic        mr;
    logic        mp;
    logic [31:0] pc;
    logic        busy;
    logic [6:0]  exp;
  } vec_t;

  vec_t vecs[16];

  // scoreboard compare
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic drive(input logic idv, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic u2, input logic exv, input logic [4:0] rd,
                       input logic mr, input logic mp, input logic [31:0] pc,
                       input logic busy);
    id_valid = idv; id_rs1 = rs1; id_rs2 = rs2; id_uses_rs2 = u2;
    ex_valid = exv; ex_rd = rd; ex_memread = mr; ex_mispredict = mp;
    ex_redirect_pc = pc; mem_busy = busy;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic load_use_in();
    drive(1'b1, 5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 32'h0, 1'b0);
  endtask

  // Check the current cycle's outputs of dut, then advance one clock.
  task automatic step_a(input string name, input logic [6:0] exp);
    #2;
    chk(name, {25'd0, outs_a}, {25'd0, exp});
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle();
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    vecs[0]  = '{1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 7'b1110000};
    vecs[1]  = '{1'b1, 5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 32'h0000_0004, 1'b0, 7'b0010101};
    vecs[2]  = '{1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0, 32'h0000_0008, 1'b0, 7'b1110000};
    vecs[3]  = '{1'b1, 5'd3, 5'd5, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 32'h0000_000c, 1'b0, 7'b1110000};
    vecs[4]  = '{1'b1, 5'd3, 5'd5, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 32'h0000_0010, 1'b0, 7'b0010101};
    vecs[5]  = '{1'b1, 5'd5, 5'd0, 1'b0, 1'b0, 5'd5, 1'b1, 1'b0, 32'h0000_0014, 1'b0, 7'b1110000};
    vecs[6]  = '{1'b0, 5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 32'h0000_0018, 1'b0, 7'b1110000};
    vecs[7]  = '{1'b1, 5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 32'h0000_001c, 1'b0, 7'b1110000};
    vecs[8]  = '{1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 32'h0000_0040, 1'b0, 7'b1111110};
    vecs[9]  = '{1'b1, 5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b1, 1'b1, 32'h0000_0044, 1'b0, 7'b1111110};
    vecs[10] = '{1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 32'h0000_0048, 1'b1, 7'b0000001};
    vecs[11] = '{1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 32'h0000_004c, 1'b1, 7'b0000001};
    vecs[12] = '{1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 32'h0000_0080, 1'b0, 7'b1111110};
    vecs[13] = '{1'b1, 5'd7, 5'd9, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0, 32'h0000_0084, 1'b1, 7'b0000001};
    vecs[14] = '{1'b1, 5'd7, 5'd9, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0, 32'h0000_0088, 1'b0, 7'b0010101};
    vecs[15] = '{1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 32'h0000_008c, 1'b0, 7'b1110000};

    // reset values while rst is held
    idle();
    @(posedge clk); #1;
    chk("reset_outs_d", {25'd0, outs_d}, {25'd0, 7'b0001100});
    chk("reset_outs_a", {25'd0, outs_a}, {25'd0, 7'b0001100});
    chk("reset_err", {31'd0, a_err}, 32'd0);
    chk("reset_state", {30'd0, a_dbg}, 32'd0);
    rst = 1'b0;

    // table: single-cycle decode on the default-parameter instance
    for (int i = 0; i < 16; i++) begin
      drive(vecs[i].idv, vecs[i].rs1, vecs[i].rs2, vecs[i].u2, vecs[i].exv,
            vecs[i].rd, vecs[i].mr, vecs[i].mp, vecs[i].pc, vecs[i].busy);
      #2;
      chk($sformatf("vec%0d_outs", i), {25'd0, outs_d}, {25'd0, vecs[i].exp});
      chk($sformatf("vec%0d_pc", i), d_pc, vecs[i].pc);
      @(posedge clk); #1;
    end
    idle();
    #2;
    chk("vec_end_state_d", {30'd0, d_dbg}, 32'd0);

    // load-use with LOAD_USE_STALL=3: three bubble cycles then RUN
    do_reset();
    load_use_in();
    step_a("lu_c0", 7'b0010101);
    chk("lu_state_ls", {30'd0, a_dbg}, 32'd1);
    idle();
    step_a("lu_c1", 7'b0010101);
    step_a("lu_c2", 7'b0010101);
    chk("lu_state_run", {30'd0, a_dbg}, 32'd0);
    step_a("lu_c3", 7'b1110000);

    // mispredict with FLUSH_CYCLES=3, plus a reload from inside FLUSH
    drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 32'h0000_0040, 1'b0);
    #2;
    chk("mp_pc", a_pc, 32'h0000_0040);
    step_a("mp_c0", 7'b1111110);
    chk("mp_state_flush", {30'd0, a_dbg}, 32'd2);
    idle();
    step_a("mp_c1", 7'b1111101);
    drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 32'h0000_0100, 1'b0);
    step_a("mp_reload", 7'b1111111);
    idle();
    step_a("mp_c3", 7'b1111101);
    step_a("mp_c4", 7'b1111101);
    step_a("mp_c5", 7'b1110000);

    // load-use coinciding with mispredict: redirect only, no LOAD_STALL
    drive(1'b1, 5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b1, 1'b1, 32'h0000_0200, 1'b0);
    step_a("lu_mp_c0", 7'b1111110);
    chk("lu_mp_state", {30'd0, a_dbg}, 32'd2);
    idle();
    step_a("lu_mp_c1", 7'b1111101);
    step_a("lu_mp_c2", 7'b1111101);
    step_a("lu_mp_c3", 7'b1110000);

    // mem_busy for 5 cycles in LOAD_STALL (cnt=2); resume with cnt=2
    do_reset();
    load_use_in();
    step_a("mb_c0", 7'b0010101);
    idle();
    mem_busy = 1'b1;
    for (int i = 0; i < 5; i++) step_a($sformatf("mb_busy%0d", i), 7'b0000001);
    chk("mb_state_wait", {30'd0, a_dbg}, 32'd3);
    mem_busy = 1'b0;
    step_a("mb_rel0", 7'b0010101);
    step_a("mb_rel1", 7'b0010101);
    step_a("mb_rel2", 7'b1110000);

    // timeout boundary: 3 busy cycles do not trip it, 4 do, and it sticks
    do_reset();
    mem_busy = 1'b1;
    for (int i = 0; i < 3; i++) step_a($sformatf("to_a%0d", i), 7'b0000001);
    mem_busy = 1'b0;
    step_a("to_a_rel", 7'b1110000);
    chk("to_err_after3", {31'd0, a_err}, 32'd0);
    mem_busy = 1'b1;
    for (int i = 0; i < 3; i++) step_a($sformatf("to_b%0d", i), 7'b0000001);
    chk("to_err_before4", {31'd0, a_err}, 32'd0);
    step_a("to_b3", 7'b0000001);
    chk("to_err_after4", {31'd0, a_err}, 32'd1);
    mem_busy = 1'b0;
    step_a("to_b_rel", 7'b1110000);
    step_a("to_b_idle", 7'b1110000);
    chk("to_err_sticky", {31'd0, a_err}, 32'd1);

    // asynchronous reset in the middle of FLUSH
    drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 32'h0000_0300, 1'b0);
    step_a("rf_mp", 7'b1111110);
    idle();
    #2;
    chk("rf_flush", {25'd0, outs_a}, {25'd0, 7'b1111101});
    rst = 1'b1;
    #1;
    chk("rf_outs", {25'd0, outs_a}, {25'd0, 7'b0001100});
    chk("rf_state", {30'd0, a_dbg}, 32'd0);
    chk("rf_err", {31'd0, a_err}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    step_a("rf_after", 7'b1110000);

    // final report
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
